// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// key_pkg : shared state encoding, default key width and clog2 helper
// Revision: 1.0
// ============================================================================
package key_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam int KEY_W_DEFAULT = 36;

  // Ceiling log2, floored at 1 so derived vector widths are never zero.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_index_enc.sv
`default_nettype none
// ============================================================================
// onehot_index_enc : lowest-set-bit priority encoder plus single-bit flag
// Revision: 1.0
// ============================================================================
module onehot_index_enc #(
  parameter int W     = 36,
  parameter int IDX_W = 6
) (
  input  logic [W-1:0]     x,
  output logic [IDX_W-1:0] idx,
  output logic             single
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) idx = IDX_W'(i);
    end
  end

  assign single = ((x & (x - W'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/key_target_capture.sv
`default_nettype none
// ============================================================================
// key_target_capture : debounced, one-shot-per-press key target register
// Revision: 1.0
// ============================================================================
module key_target_capture
  import key_pkg::*;
#(
  parameter  int KEY_W         = KEY_W_DEFAULT,
  parameter  int STABLE_CYCLES = 4,
  parameter  int ALLOW_MULTI   = 0,
  localparam int IDX_W         = clog2(KEY_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [KEY_W-1:0] keys_code,
  output logic [KEY_W-1:0] target_key,
  output logic [IDX_W-1:0] target_idx,
  output logic             target_valid,
  output logic             new_target
);

  localparam int             CNT_W      = clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [KEY_W-1:0]   target_key_q, target_key_d;
  logic [IDX_W-1:0]   target_idx_q, target_idx_d;
  logic               target_valid_q, target_valid_d;
  logic               new_target_q, new_target_d;

  logic [IDX_W-1:0]   key_idx;
  logic               key_single;
  logic               key_ok;
  logic               capture;

  // At any capture keys_code equals the candidate, so one encoder serves both
  // the validity check and the index calculation.
  onehot_index_enc #(
    .W     (KEY_W),
    .IDX_W (IDX_W)
  ) u_enc (
    .x      (keys_code),
    .idx    (key_idx),
    .single (key_single)
  );

  assign key_ok = (keys_code != '0) && ((ALLOW_MULTI != 0) || key_single);

  always_comb begin
    state_d        = state_q;
    cand_d         = cand_q;
    count_d        = count_q;
    target_key_d   = target_key_q;
    target_idx_d   = target_idx_q;
    target_valid_d = target_valid_q;
    new_target_d   = 1'b0;
    capture        = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_ok) begin
          cand_d  = keys_code;
          count_d = CNT_W'(1);
          if (STABLE_CYCLES == 1) begin
            capture = 1'b1;
            state_d = WAIT_REL;
          end else begin
            state_d = QUAL;
          end
        end
      end
      QUAL: begin
        if (keys_code == cand_q) begin
          count_d = count_q + CNT_W'(1);
          if (count_d == STABLE_CNT) begin
            capture = 1'b1;
            state_d = WAIT_REL;
          end
        end else if (key_ok) begin
          cand_d  = keys_code;
          count_d = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_REL: begin
        if (keys_code == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      target_key_d   = keys_code;
      target_idx_d   = key_idx;
      target_valid_d = 1'b1;
      new_target_d   = 1'b1;
    end

    // A key still held when the game changes state must not be reused.
    if (clear) begin
      cand_d         = cand_q;
      count_d        = '0;
      target_key_d   = '0;
      target_idx_d   = '0;
      target_valid_d = 1'b0;
      new_target_d   = 1'b0;
      state_d        = (keys_code != '0) ? WAIT_REL : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cand_q         <= '0;
      count_q        <= '0;
      target_key_q   <= '0;
      target_idx_q   <= '0;
      target_valid_q <= 1'b0;
      new_target_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      count_q        <= count_d;
      target_key_q   <= target_key_d;
      target_idx_q   <= target_idx_d;
      target_valid_q <= target_valid_d;
      new_target_q   <= new_target_d;
    end
  end

  assign target_key   = target_key_q;
  assign target_idx   = target_idx_q;
  assign target_valid = target_valid_q;
  assign new_target   = new_target_q;

endmodule
`default_nettype wire

// File: tb/tb_key_target_capture.sv
`default_nettype none
// ============================================================================
// tb_key_target_capture : directed stimulus, run-length reference model
// Revision: 1.0
// ============================================================================
module tb_key_target_capture;

  localparam int KW = 36;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [KW-1:0] keys;

  logic [KW-1:0] key0, key1;
  logic [5:0]    idx0, idx1;
  logic          val0, val1, new0, new1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_target_capture #(.KEY_W(KW), .STABLE_CYCLES(S), .ALLOW_MULTI(0)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .keys_code(keys),
    .target_key(key0), .target_idx(idx0), .target_valid(val0), .new_target(new0)
  );

  key_target_capture #(.KEY_W(KW), .STABLE_CYCLES(S), .ALLOW_MULTI(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .keys_code(keys),
    .target_key(key1), .target_idx(idx1), .target_valid(val1), .new_target(new1)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a capture happens when S consecutive identical valid
  // samples are seen while not blocked; blocking lasts until a zero sample.
  logic [KW-1:0] m_key[2];
  logic [5:0]    m_idx[2];
  logic          m_valid[2];
  logic          m_new[2];
  logic          m_blocked[2];
  logic [KW-1:0] m_run[2];
  int            m_len[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        m_key[m] <= '0; m_idx[m] <= '0; m_valid[m] <= 1'b0; m_new[m] <= 1'b0;
        m_blocked[m] <= 1'b0; m_run[m] <= '0; m_len[m] <= 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        automatic logic ok = (keys != '0) && (m == 1 || $countones(keys) == 1);
        automatic int   len = m_len[m];
        m_new[m] <= 1'b0;
        if (clear) begin
          m_key[m] <= '0; m_idx[m] <= '0; m_valid[m] <= 1'b0;
          m_blocked[m] <= (keys != '0);
          m_len[m] <= 0;
        end else if (m_blocked[m]) begin
          if (keys == '0) m_blocked[m] <= 1'b0;
          m_len[m] <= 0;
        end else if (ok) begin
          len = (len > 0 && keys == m_run[m]) ? len + 1 : 1;
          m_run[m] <= keys;
          if (len == S) begin
            m_key[m]     <= keys;
            m_idx[m]     <= 6'($clog2(keys & (~keys + 1'b1)));
            m_valid[m]   <= 1'b1;
            m_new[m]     <= 1'b1;
            m_blocked[m] <= 1'b1;
            len = 0;
          end
          m_len[m] <= len;
        end else begin
          m_len[m] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("m0_key",   64'(key0), 64'(m_key[0]));
    check("m0_idx",   64'(idx0), 64'(m_idx[0]));
    check("m0_valid", 64'(val0), 64'(m_valid[0]));
    check("m0_new",   64'(new0), 64'(m_new[0]));
    check("m1_key",   64'(key1), 64'(m_key[1]));
    check("m1_idx",   64'(idx1), 64'(m_idx[1]));
    check("m1_valid", 64'(val1), 64'(m_valid[1]));
    check("m1_new",   64'(new1), 64'(m_new[1]));
  end

  task automatic drive(input logic [KW-1:0] code, input logic clr, input int n);
    keys  = code;
    clear = clr;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0, c1;
    rst = 1'b1; clear = 1'b0; keys = 36'h1;
    repeat (3) @(negedge clk);
    check("rst_key",   64'(key0), 64'h0);
    check("rst_valid", 64'(val0), 64'h0);
    check("rst_new",   64'(new0), 64'h0);
    rst = 1'b0;

    // Capture after the fourth edge following reset release
    drive(36'h1, 1'b0, 3);
    check("pre_cap_valid", 64'(val0), 64'h0);
    drive(36'h1, 1'b0, 1);
    check("cap1_new", 64'(new0), 64'h1);
    check("cap1_key", 64'(key0), 64'h1);
    check("cap1_idx", 64'(idx0), 64'h0);
    drive(36'h1, 1'b0, 1);
    check("cap1_pulse_end", 64'(new0), 64'h0);

    // Glitch shorter than the qualification window
    drive(36'h0, 1'b1, 1);
    check("clr_valid", 64'(val0), 64'h0);
    drive(36'h4, 1'b0, 3);
    drive(36'h0, 1'b0, 2);
    check("glitch_valid", 64'(val0), 64'h0);

    // Long hold yields one pulse; release then re-press yields another
    c0 = 0;
    for (int i = 0; i < 20; i++) begin
      drive(36'h800, 1'b0, 1);
      if (new0) c0++;
    end
    check("hold_pulses", 64'(c0), 64'd1);
    check("hold_idx",    64'(idx0), 64'd11);
    drive(36'h0, 1'b0, 1);
    drive(36'h800, 1'b0, 4);
    check("repress_new", 64'(new0), 64'h1);
    drive(36'h0, 1'b0, 1);

    // Multi-bit code: rejected at ALLOW_MULTI=0, captured at 1
    c0 = 0; c1 = 0;
    for (int i = 0; i < 10; i++) begin
      drive(36'h3, 1'b0, 1);
      if (new0) c0++;
      if (new1) c1++;
    end
    check("multi0_pulses", 64'(c0), 64'd0);
    check("multi1_pulses", 64'(c1), 64'd1);
    check("multi1_key",    64'(key1), 64'h3);
    check("multi1_idx",    64'(idx1), 64'h0);
    drive(36'h0, 1'b0, 1);

    // Candidate switch restarts qualification
    drive(36'h10, 1'b0, 2);
    drive(36'h20, 1'b0, 3);
    check("switch_early", 64'(new0), 64'h0);
    drive(36'h20, 1'b0, 1);
    check("switch_new", 64'(new0), 64'h1);
    check("switch_key", 64'(key0), 64'h20);
    check("switch_idx", 64'(idx0), 64'd5);
    drive(36'h0, 1'b0, 1);

    // Clear while held: no reuse until released and re-qualified
    drive(36'h2, 1'b0, 4);
    check("k2_new", 64'(new0), 64'h1);
    drive(36'h2, 1'b1, 1);
    check("held_clr_valid", 64'(val0), 64'h0);
    check("held_clr_key",   64'(key0), 64'h0);
    drive(36'h2, 1'b0, 6);
    check("held_no_recap", 64'(val0), 64'h0);
    drive(36'h0, 1'b0, 1);
    drive(36'h2, 1'b0, 3);
    check("requal_early", 64'(val0), 64'h0);
    drive(36'h2, 1'b0, 1);
    check("requal_new", 64'(new0), 64'h1);
    check("requal_key", 64'(key0), 64'h2);

    // Clear on the capture edge wins
    drive(36'h0, 1'b0, 1);
    drive(36'h4, 1'b0, 3);
    drive(36'h4, 1'b1, 1);
    check("clr_cap_new",   64'(new0), 64'h0);
    check("clr_cap_valid", 64'(val0), 64'h0);
    drive(36'h4, 1'b0, 5);
    check("clr_cap_after", 64'(val0), 64'h0);

    // Reset mid-qualification discards the candidate
    drive(36'h0, 1'b0, 1);
    drive(36'h8, 1'b0, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(36'h8, 1'b0, 3);
    check("rst_mid_valid", 64'(val0), 64'h0);
    drive(36'h8, 1'b0, 1);
    check("rst_mid_new", 64'(new0), 64'h1);
    check("rst_mid_idx", 64'(idx0), 64'd3);
    drive(36'h0, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_target_capture.md
# key_target_capture

Clocked, parametrised key-capture stage between the keyboard decoder and the game FSM. Replaces the combinational hold-last-nonzero latch with a registered design. A key code is captured only after it has been stable for a programmable number of cycles. One capture is made per press/release. Multi-key codes are rejected, the captured code is also output as a bit index, and the game FSM can clear the target on a state change.

## Interface
Parameters:
- KEY_W, 36, width of the one-hot key code (26 letters + 10 digits).
- STABLE_CYCLES, 4, consecutive identical samples required before capture; legal range 1..255.
- ALLOW_MULTI, 0, 0 = codes with more than one bit set are invalid; 1 = accepted, index reports lowest set bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear from game FSM (state change).
- keys_code  in  KEY_W  key code from the decoder; 0 = no key.
- target_key  out  KEY_W  last captured code, registered.
- target_idx  out  IDX_W (= clog2(KEY_W), 6 at default)  bit index of target_key.
- target_valid  out  1  high while target_key holds a capture made since the last reset/clear.
- new_target  out  1  one-cycle pulse, coincident with the cycle target_key first shows a new capture.

## Operation
- Valid code: nonzero, and (ALLOW_MULTI=1 or exactly one bit set). Any other nonzero code is invalid.
- State IDLE (armed):
  - On a valid code, latch candidate and set count=1.
  - If STABLE_CYCLES=1, capture immediately and go to WAIT_REL.
  - Otherwise go to QUAL.
- State QUAL:
  - keys_code == candidate: count++. When count reaches STABLE_CYCLES, capture and go to WAIT_REL.
  - Different valid code: reload candidate, count=1, stay in QUAL.
  - Zero or invalid code: go to IDLE, no capture.
- State WAIT_REL: ignore all nonzero codes (including invalid ones). Go to IDLE on the first cycle keys_code==0.
- Capture: target_key<=candidate, target_idx<=encode(candidate), target_valid<=1, new_target<=1. Re-pressing the same key produces a new capture and pulse.
- clear (priority over every FSM action):
  - target_key<=0, target_idx<=0, target_valid<=0, new_target<=0, count<=0.
  - Next state is WAIT_REL if keys_code!=0, else IDLE. A key held across a game-state change is never reused.
- Outputs hold their value in all states except on a capture or a clear.

## Timing
- Reset (async assert): state=IDLE, candidate=0, count=0, target_key=0, target_idx=0, target_valid=0, new_target=0.
- Latency: first valid sample at edge k, with keys_code held through edge k+STABLE_CYCLES-1. Outputs update after edge k+STABLE_CYCLES-1. new_target is high for exactly that one following cycle.
- new_target is never high on two consecutive cycles; a minimum of STABLE_CYCLES+1 cycles separates pulses (release cycle plus requalification).
- Capture and clear on the same edge: clear wins, no pulse.
- Reset mid-QUAL discards the candidate; no capture.
- The counter is clog2(STABLE_CYCLES+1) bits and cannot wrap, because QUAL exits at STABLE_CYCLES.

## Structure
- Shared package key_pkg:
  - state encoding (IDLE=2'd0, QUAL=2'd1, WAIT_REL=2'd2);
  - KEY_W_DEFAULT=36;
  - clog2 function.
- Sub-module onehot_index_enc (parametrised width, lowest-set-bit priority encoder, combinational). Used to compute target_idx at capture and the single-bit validity check (popcount ≤ 1 via x & (x-1) == 0).

## Test plan
- Reset with keys_code=36'h1 held: outputs all zero. After release of reset, capture occurs after 4 edges; target_idx=0, one new_target pulse.
- Glitch: keys_code=36'h4 for 3 cycles then 0 → no capture, target_valid stays 0.
- Hold 36'h800 for 20 cycles → exactly one pulse, target_idx=11. Release 1 cycle, hold again 4 cycles → second pulse.
- ALLOW_MULTI=0: keys_code=36'h3 for 10 cycles → no capture. With ALLOW_MULTI=1, same stimulus → target_key=36'h3, target_idx=0.
- Candidate switch: 36'h10 for 2 cycles then 36'h20 for 4 → capture 36'h20 only, after 4 cycles of 36'h20.
- clear while 36'h2 held after a capture: target_valid=0 next cycle; no recapture until keys_code=0 then 36'h2 for 4 cycles. A clear asserted on the capture edge suppresses the pulse.
